// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with load-use hazard detection.
// Latches the decoder control bundle and decode-stage operands into EX.
// A load-use pair triggers a one-cycle stall and a bubble. A taken
// branch or jump (flush_i) also inserts a bubble. A downstream busy
// signal (hold_i) freezes the register.
// Optional feature: define ID_EX_PERF_CNT_EN to add the bubble and hold
// event counters (bubble_cnt_o, hold_cnt_o).
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] pc4_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        shamt_i,
    input  logic [5:0]        funct_i,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] pc4_o,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [4:0]        rs_o,
    output logic [4:0]        rt_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        shamt_o,
    output logic [5:0]        funct_o,
    output logic              valid_o,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]       bubble_cnt_o,
    output logic [31:0]       hold_cnt_o,
`endif
    output logic              stall_o
);

    // Control bundle bit positions (LSB first).
    localparam int unsigned C_REGDST   = 0;
    localparam int unsigned C_MEMREAD  = 4;
    localparam int unsigned C_MEMWRITE = 5;
    localparam int unsigned C_BRANCH   = 6;

    // Action taken at the next edge, in priority order.
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_HOLD   = 2'd2
    } act_t;

    act_t act;
    logic rt_src;
    logic hz;

    // Load-use hazard: a load in EX whose destination rt feeds the ID instruction.
    always_comb begin
        rt_src = ctrl_i[C_REGDST] | ctrl_i[C_MEMWRITE] | ctrl_i[C_BRANCH];
        hz     = valid_o & ctrl_o[C_MEMREAD] & (rt_o != 5'd0) &
                 ((rt_o == rs_i) | ((rt_o == rt_i) & rt_src));
    end

    // Select the edge action and the stall request (hold and flush mask the stall).
    always_comb begin
        act     = ACT_LOAD;
        stall_o = 1'b0;
        if (hold_i) begin
            act = ACT_HOLD;
        end else if (flush_i || hz) begin
            act     = ACT_BUBBLE;
            stall_o = hz & ~flush_i;
        end
    end

    // Pipeline register: hold keeps everything. A bubble still loads the
    // data fields but zeroes the control bits and clears valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_o    <= '0;
            pc4_o     <= '0;
            rs_data_o <= '0;
            rt_data_o <= '0;
            imm_o     <= '0;
            rs_o      <= '0;
            rt_o      <= '0;
            rd_o      <= '0;
            shamt_o   <= '0;
            funct_o   <= '0;
            valid_o   <= 1'b0;
        end else if (act != ACT_HOLD) begin
            pc4_o     <= pc4_i;
            rs_data_o <= rs_data_i;
            rt_data_o <= rt_data_i;
            imm_o     <= imm_i;
            rs_o      <= rs_i;
            rt_o      <= rt_i;
            rd_o      <= rd_i;
            shamt_o   <= shamt_i;
            funct_o   <= funct_i;
            if (act == ACT_BUBBLE) begin
                ctrl_o  <= '0;
                valid_o <= 1'b0;
            end else begin
                ctrl_o  <= ctrl_i;
                valid_o <= 1'b1;
            end
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    // Event counters: bubbles inserted and held edges. Both wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_o <= '0;
            hold_cnt_o   <= '0;
        end else begin
            if (act == ACT_BUBBLE) bubble_cnt_o <= bubble_cnt_o + 32'd1;
            if (act == ACT_HOLD)   hold_cnt_o   <= hold_cnt_o + 32'd1;
        end
    end
`endif

endmodule
